// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one 4-bit signed compare slice (add/sub in subtract mode)
// among four requesters, with a registered req/gnt/valid handshake.

module adder_subtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  output logic [3:0] S,
  output logic       V
);
  logic [3:0] b_x;

  always_comb begin
    b_x = B ^ {4{M}};
    S   = A + b_x + {3'b000, M};
    V   = (A[3] == b_x[3]) && (S[3] != A[3]);
  end
endmodule

module cmp_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                  inp_clk,
  input  logic                  inp_rst_n,
  input  logic [NREQ-1:0]       inp_req,
  input  logic [NREQ*WIDTH-1:0] inp_A_bus,
  input  logic [NREQ*WIDTH-1:0] inp_B_bus,
  output logic [NREQ-1:0]       out_gnt,
  output logic [1:0]            out_id,
  output logic                  out_valid,
  output logic                  out_AequalB,
  output logic                  out_AgreaterB,
  output logic                  out_BgreaterA,
  output logic                  out_busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic [3:0] a_r, b_r;
  logic [3:0] diff;
  logic       ovf;

  adder_subtractor u_addsub (
    .A (a_r),
    .B (b_r),
    .M (1'b1),
    .S (diff),
    .V (ovf)
  );

  // Scan from the rotating pointer; the first requester found wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && inp_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|inp_req) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_busy = (state != IDLE);
  end

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      out_gnt       <= '0;
      out_id        <= '0;
      out_valid     <= 1'b0;
      out_AequalB   <= 1'b0;
      out_AgreaterB <= 1'b0;
      out_BgreaterA <= 1'b0;
      ptr           <= '0;
      a_r           <= '0;
      b_r           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|inp_req) begin
            out_gnt <= NREQ'(1) << win;
            out_id  <= win;
            a_r     <= inp_A_bus[{win, 2'b00} +: 4];
            b_r     <= inp_B_bus[{win, 2'b00} +: 4];
          end
        end
        EXEC: begin
          out_valid     <= 1'b1;
          out_AequalB   <= (a_r == b_r);
          out_AgreaterB <= (a_r != b_r) && !(diff[3] ^ ovf);
          out_BgreaterA <= diff[3] ^ ovf;
        end
        DONE: begin
          out_valid <= 1'b0;
          out_gnt   <= '0;
          ptr       <= out_id + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: vector table plus reset and rotation sequences.

module tb_cmp_share_arbiter;
  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] a_bus, b_bus;
  logic [3:0]  gnt;
  logic [1:0]  id;
  logic        valid, eq, gt, lt, busy;

  int errors = 0;
  int checks = 0;

  cmp_share_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .inp_clk       (clk),
    .inp_rst_n     (rst_n),
    .inp_req       (req),
    .inp_A_bus     (a_bus),
    .inp_B_bus     (b_bus),
    .out_gnt       (gnt),
    .out_id        (id),
    .out_valid     (valid),
    .out_AequalB   (eq),
    .out_AgreaterB (gt),
    .out_BgreaterA (lt),
    .out_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  id;
    logic        eq;
    logic        gt;
    logic        lt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"}, 32'(gnt), 32'h0);
    check({tag, " id"}, 32'(id), 32'h0);
    check({tag, " valid"}, 32'(valid), 32'h0);
    check({tag, " flags"}, 32'({eq, gt, lt}), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  int n_valid;
  int exp_id;

  initial begin
    // pointer starts at 0; each entry leaves it at id+1
    vecs[0] = '{4'b0001, 16'h4215, 16'h6703, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{4'b0001, 16'h1237, 16'h4568, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'b0001, 16'h0008, 16'h9997, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'b0001, 16'h123A, 16'h567A, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'b0110, 16'h55F5, 16'h1121, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'b1001, 16'h3000, 16'hF777, 2'd3, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'b1010, 16'h5005, 16'h1001, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'b0011, 16'h000E, 16'h000D, 2'd0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    #1;
    check_all_zero("reset");
    cycle();
    rst_n = 1'b1;
    cycle();
    check("idle busy", 32'(busy), 32'h0);
    check("idle gnt", 32'(gnt), 32'h0);

    foreach (vecs[v]) begin
      req   = vecs[v].req;
      a_bus = vecs[v].a;
      b_bus = vecs[v].b;
      cycle();
      check($sformatf("v%0d gnt", v), 32'(gnt), 32'(4'b0001 << vecs[v].id));
      check($sformatf("v%0d id", v), 32'(id), 32'(vecs[v].id));
      check($sformatf("v%0d busy", v), 32'(busy), 32'h1);
      check($sformatf("v%0d early valid", v), 32'(valid), 32'h0);
      // operands after capture must be ignored
      a_bus = ~vecs[v].a;
      b_bus = 16'h0000;
      cycle();
      check($sformatf("v%0d valid", v), 32'(valid), 32'h1);
      check($sformatf("v%0d flags", v), 32'({eq, gt, lt}),
            32'({vecs[v].eq, vecs[v].gt, vecs[v].lt}));
      req = '0;
      cycle();
      check($sformatf("v%0d valid drop", v), 32'(valid), 32'h0);
      check($sformatf("v%0d gnt drop", v), 32'(gnt), 32'h0);
      check($sformatf("v%0d busy drop", v), 32'(busy), 32'h0);
      check($sformatf("v%0d flags hold", v), 32'({eq, gt, lt}),
            32'({vecs[v].eq, vecs[v].gt, vecs[v].lt}));
      check($sformatf("v%0d id hold", v), 32'(id), 32'(vecs[v].id));
    end

    // requester dropping req during EXEC still gets its result
    req   = 4'b0001;
    a_bus = 16'h0002;
    b_bus = 16'h0001;
    cycle();
    req = '0;
    cycle();
    check("drop valid", 32'(valid), 32'h1);
    check("drop flags", 32'({eq, gt, lt}), 32'b010);
    cycle();

    // reset mid-operation: async clear, no valid afterwards
    req   = 4'b0100;
    a_bus = 16'h0300;
    b_bus = 16'h0100;
    cycle();
    check("pre-reset gnt", 32'(gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    n_valid = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (valid) n_valid++;
    end
    req = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (valid) n_valid++;
    end
    check("aborted op valid count", 32'(n_valid), 32'h0);
    check("post-reset busy", 32'(busy), 32'h0);

    // all requesting: strict rotation restarting at 0, valid on cycles 2,5,8,11
    req   = 4'b1111;
    a_bus = 16'h7531;
    b_bus = 16'h1357;
    n_valid = 0;
    exp_id = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (c % 3 == 1) begin
        check($sformatf("rot gnt c%0d", c), 32'(gnt), 32'(4'b0001 << exp_id));
      end
      if (c % 3 == 2) begin
        check($sformatf("rot valid c%0d", c), 32'(valid), 32'h1);
        check($sformatf("rot id c%0d", c), 32'(id), 32'(exp_id));
        exp_id = (exp_id + 1) % 4;
      end else begin
        check($sformatf("rot no valid c%0d", c), 32'(valid), 32'h0);
      end
      if (valid) n_valid++;
    end
    check("rot valid count", 32'(n_valid), 32'd4);
    req = '0;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
